// File: rtl/led_seq_pkg.sv
// Shared types and constants for the button-driven LED sequencer.
package led_seq_pkg;

    localparam int unsigned LED_W    = 4;
    localparam int unsigned SPD_W    = 3;
    localparam int unsigned MODE_W   = 2;
    localparam int unsigned MODE_CNT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef enum logic [MODE_W-1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_COUNT  = 2'd2
    } mode_t;

    localparam logic [LED_W-1:0] SEED_ROTATE = 4'b0001;
    localparam logic [LED_W-1:0] SEED_BOUNCE = 4'b0001;
    localparam logic [LED_W-1:0] SEED_COUNT  = 4'b0000;

    // Pattern loaded when a run starts from IDLE.
    function automatic logic [LED_W-1:0] mode_seed(input mode_t m);
        case (m)
            MODE_ROTATE: return SEED_ROTATE;
            MODE_BOUNCE: return SEED_BOUNCE;
            MODE_COUNT:  return SEED_COUNT;
            default:     return SEED_COUNT;
        endcase
    endfunction

    // Cycle through the MODE_CNT valid modes, wrapping back to ROTATE.
    function automatic mode_t mode_next(input mode_t m);
        case (m)
            MODE_ROTATE: return MODE_BOUNCE;
            MODE_BOUNCE: return MODE_COUNT;
            default:     return MODE_ROTATE;
        endcase
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// Prescaler issuing a one-cycle step every (BASE_DIV >> speed) enabled cycles.
// A count left beyond a shortened limit falls back to 0 without a step.
module led_step_timer
    import led_seq_pkg::*;
#(
    parameter int unsigned BASE_DIV = 12500000,
    parameter int unsigned CNT_W    = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             clr,
    input  logic [SPD_W-1:0] speed,
    output logic             step_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last_c;

    assign last_c = CNT_W'(BASE_DIV >> speed) - CNT_W'(1);
    assign step_c = en && (cnt_q == last_c);

    // Count while enabled; wrap at or beyond the terminal value.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q >= last_c) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// Button-driven LED sequencer: arbitrated commands, IDLE/RUN/PAUSE FSM and
// a 4-bit pattern stepped at a selectable rate.
// Optional macro LED_SEQ_PAUSE_BLINK_EN blinks the frozen pattern in PAUSE.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned BASE_DIV = 12500000,
    parameter int unsigned SPD_MAX  = 3,
    parameter int unsigned CNT_W    = 24
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BTN_START,
    input  logic              BTN_MODE,
    input  logic              BTN_UP,
    input  logic              BTN_DOWN,
    output logic [LED_W-1:0]  LED,
    output logic              RUNNING,
    output logic [SPD_W-1:0]  SPEED,
    output logic [MODE_W-1:0] MODE
);

    localparam logic [SPD_W-1:0] SPD_TOP = SPD_W'(SPD_MAX);

    state_t           state_q, state_nxt;
    mode_t            mode_q, mode_nxt;
    logic [SPD_W-1:0] speed_q, speed_nxt;
    logic [LED_W-1:0] pat_q, pat_nxt;
    logic             dir_left_q, dir_left_nxt;
    logic             bounce_left_c;
    logic             tmr_clr_c;
    logic             step_c;

    led_step_timer #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_step (
        .CLK    (CLK),
        .RST    (RST),
        .en     (state_q == ST_RUN),
        .clr    (tmr_clr_c),
        .speed  (speed_q),
        .step_c (step_c)
    );

    // State and pattern registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_ROTATE;
            speed_q    <= '0;
            pat_q      <= '0;
            dir_left_q <= 1'b1;
            RUNNING    <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            mode_q     <= mode_nxt;
            speed_q    <= speed_nxt;
            pat_q      <= pat_nxt;
            dir_left_q <= dir_left_nxt;
            RUNNING    <= (state_nxt == ST_RUN);
        end
    end

    // Command arbitration (START > MODE > UP > DOWN), then step if no command.
    always_comb begin
        state_nxt     = state_q;
        mode_nxt      = mode_q;
        speed_nxt     = speed_q;
        pat_nxt       = pat_q;
        dir_left_nxt  = dir_left_q;
        tmr_clr_c     = 1'b0;
        bounce_left_c = dir_left_q;
        if (pat_q[LED_W-1]) begin
            bounce_left_c = 1'b0;
        end else if (pat_q[0]) begin
            bounce_left_c = 1'b1;
        end

        if (BTN_START) begin
            case (state_q)
                ST_IDLE: begin
                    state_nxt    = ST_RUN;
                    pat_nxt      = mode_seed(mode_q);
                    dir_left_nxt = 1'b1;
                    tmr_clr_c    = 1'b1;
                end
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end else if (BTN_MODE) begin
            mode_nxt     = mode_next(mode_q);
            state_nxt    = ST_IDLE;
            pat_nxt      = '0;
            dir_left_nxt = 1'b1;
        end else if (BTN_UP) begin
            if (speed_q < SPD_TOP) begin
                speed_nxt = speed_q + SPD_W'(1);
            end
        end else if (BTN_DOWN) begin
            if (speed_q != '0) begin
                speed_nxt = speed_q - SPD_W'(1);
            end
        end else if (step_c) begin
            case (mode_q)
                MODE_ROTATE: pat_nxt = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                MODE_BOUNCE: begin
                    pat_nxt      = bounce_left_c ? (pat_q << 1) : (pat_q >> 1);
                    dir_left_nxt = bounce_left_c;
                end
                MODE_COUNT:  pat_nxt = pat_q + LED_W'(1);
                default:     pat_nxt = pat_q;
            endcase
        end
    end

    assign SPEED = speed_q;
    assign MODE  = mode_q;

`ifdef LED_SEQ_PAUSE_BLINK_EN
    logic blink_step_c;
    logic phase_q, phase_nxt;

    led_step_timer #(
        .BASE_DIV (BASE_DIV * 2),
        .CNT_W    (CNT_W + 1)
    ) u_blink (
        .CLK    (CLK),
        .RST    (RST),
        .en     (state_q == ST_PAUSE),
        .clr    (state_q != ST_PAUSE),
        .speed  ('0),
        .step_c (blink_step_c)
    );

    // Blink phase: on at PAUSE entry, toggles on each blink tick while paused.
    always_comb begin
        phase_nxt = 1'b1;
        if ((state_q == ST_PAUSE) && (state_nxt == ST_PAUSE)) begin
            phase_nxt = phase_q ^ blink_step_c;
        end
    end

    // Displayed pattern, masked by the blink phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase_q <= 1'b1;
            LED     <= '0;
        end else begin
            phase_q <= phase_nxt;
            LED     <= pat_nxt & {LED_W{phase_nxt}};
        end
    end
`else
    assign LED = pat_q;
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized and directed bench for led_seq_ctrl against a behavioural model.
`timescale 1ns/1ps
module tb_led_seq_ctrl;

    localparam int unsigned BD   = 16;
    localparam int unsigned SMAX = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       BTN_START = 1'b0, BTN_MODE = 1'b0, BTN_UP = 1'b0, BTN_DOWN = 1'b0;
    logic [3:0] LED;
    logic       RUNNING;
    logic [2:0] SPEED;
    logic [1:0] MODE;

    int checks = 0;
    int errors = 0;

    // Model: state 0 idle, 1 run, 2 pause
    int m_state, m_mode, m_speed, m_cnt, m_pat, m_bidx, m_bcnt;
    bit m_phase;
    int bounce_seq [6] = '{1, 2, 4, 8, 4, 2};

    led_seq_ctrl #(.BASE_DIV(BD), .SPD_MAX(SMAX), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST), .BTN_START(BTN_START), .BTN_MODE(BTN_MODE),
        .BTN_UP(BTN_UP), .BTN_DOWN(BTN_DOWN), .LED(LED), .RUNNING(RUNNING),
        .SPEED(SPEED), .MODE(MODE)
    );

    always #5 CLK = ~CLK;

    function automatic int exp_led();
`ifdef LED_SEQ_PAUSE_BLINK_EN
        if (m_state == 2 && !m_phase) return 0;
`endif
        return m_pat;
    endfunction

    task automatic model_reset();
        m_state = 0; m_mode = 0; m_speed = 0; m_cnt = 0;
        m_pat = 0; m_bidx = 0; m_bcnt = 0; m_phase = 1'b1;
    endtask

    task automatic model_step(input bit s, input bit m, input bit u, input bit d, input bit r);
        int per;
        int old_state;
        bit fire;
        if (r) begin
            model_reset();
            return;
        end
        old_state = m_state;
        per = BD >> m_speed;
        fire = 1'b0;
        if (s && m_state == 0) m_cnt = 0;
        else if (m_state == 1) begin
            if (m_cnt == per - 1) begin fire = 1'b1; m_cnt = 0; end
            else if (m_cnt >= per) m_cnt = 0;
            else m_cnt++;
        end
        if (s) begin
            if (m_state == 0) begin
                m_state = 1; m_pat = (m_mode == 2) ? 0 : 1; m_bidx = 0;
            end else if (m_state == 1) m_state = 2;
            else m_state = 1;
        end else if (m) begin
            m_mode = (m_mode + 1) % 3; m_state = 0; m_pat = 0;
        end else if (u) begin
            if (m_speed < SMAX) m_speed++;
        end else if (d) begin
            if (m_speed > 0) m_speed--;
        end else if (fire) begin
            if (m_mode == 0) m_pat = ((m_pat << 1) | (m_pat >> 3)) & 15;
            else if (m_mode == 1) begin m_bidx = (m_bidx + 1) % 6; m_pat = bounce_seq[m_bidx]; end
            else m_pat = (m_pat + 1) % 16;
        end
        if (m_state == 2) begin
            if (old_state != 2) begin m_phase = 1'b1; m_bcnt = 0; end
            else if (m_bcnt == 2 * BD - 1) begin m_phase = !m_phase; m_bcnt = 0; end
            else m_bcnt++;
        end else begin
            m_phase = 1'b1;
        end
    endtask

    task automatic tick(input bit s, input bit m, input bit u, input bit d, input bit r);
        BTN_START = s; BTN_MODE = m; BTN_UP = u; BTN_DOWN = d; RST = r;
        @(posedge CLK); #1;
        BTN_START = 0; BTN_MODE = 0; BTN_UP = 0; BTN_DOWN = 0; RST = 0;
        model_step(s, m, u, d, r);
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        checks++;
        if (LED !== 4'b0000 || RUNNING !== 1'b0 || SPEED !== 3'd0 || MODE !== 2'd0) begin
            errors++;
            $display("FAIL reset got led=%b run=%b spd=%0d mode=%0d exp 0000/0/0/0", LED, RUNNING, SPEED, MODE);
        end
    endtask

    task automatic test_rotate();
        tick(1, 0, 0, 0, 0);
        checks++;
        if (RUNNING !== 1'b1 || LED !== 4'b0001) begin
            errors++; $display("FAIL rot_start got run=%b led=%b exp 1/0001", RUNNING, LED);
        end
        repeat (15) tick(0, 0, 0, 0, 0);
        checks++;
        if (LED !== 4'b0001) begin errors++; $display("FAIL rot_hold got %b exp 0001", LED); end
        tick(0, 0, 0, 0, 0);
        checks++;
        if (LED !== 4'b0010) begin errors++; $display("FAIL rot_step1 got %b exp 0010", LED); end
        repeat (48) tick(0, 0, 0, 0, 0);
        checks++;
        if (LED !== 4'b0001) begin errors++; $display("FAIL rot_wrap got %b exp 0001", LED); end
    endtask

    task automatic test_speed();
        int changes;
        logic [3:0] prev;
        for (int i = 1; i <= 4; i++) begin
            tick(0, 0, 1, 0, 0);
            checks++;
            if (SPEED !== 3'((i > 3) ? 3 : i)) begin
                errors++; $display("FAIL speed_up%0d got %0d exp %0d", i, SPEED, (i > 3) ? 3 : i);
            end
        end
        repeat (4) tick(0, 0, 0, 0, 0);
        changes = 0;
        prev = LED;
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, 0, 0, 0);
            if (LED !== prev) changes++;
            prev = LED;
        end
        checks++;
        if (changes != 8) begin errors++; $display("FAIL speed_rate got %0d steps exp 8", changes); end
        for (int i = 1; i <= 4; i++) begin
            tick(0, 0, 0, 1, 0);
            checks++;
            if (SPEED !== 3'((i > 3) ? 0 : 3 - i)) begin
                errors++; $display("FAIL speed_down%0d got %0d exp %0d", i, SPEED, (i > 3) ? 0 : 3 - i);
            end
        end
    endtask

    task automatic test_priority();
        logic [3:0] frozen;
        logic [3:0] want;
        tick(1, 1, 1, 0, 0);
        frozen = 4'(m_pat);
        checks++;
        if (RUNNING !== 1'b0 || MODE !== 2'd0 || SPEED !== 3'd0) begin
            errors++; $display("FAIL prio got run=%b mode=%0d spd=%0d exp 0/0/0", RUNNING, MODE, SPEED);
        end
        for (int i = 0; i < 100; i++) begin
            if (i > 0) tick(0, 0, 0, 0, 0);
            want = frozen;
`ifdef LED_SEQ_PAUSE_BLINK_EN
            if (((i / 32) % 2) == 1) want = 4'b0000;
`endif
            checks++;
            if (LED !== want) begin errors++; $display("FAIL pause_led i=%0d got %b exp %b", i, LED, want); end
        end
        tick(1, 0, 0, 0, 0);
        checks++;
        if (RUNNING !== 1'b1 || LED !== frozen) begin
            errors++; $display("FAIL resume got run=%b led=%b exp 1/%b", RUNNING, LED, frozen);
        end
    endtask

    task automatic test_bounce();
        int exp_seq [7] = '{2, 4, 8, 4, 2, 1, 2};
        tick(0, 1, 0, 0, 0);
        checks++;
        if (MODE !== 2'd1 || RUNNING !== 1'b0 || LED !== 4'b0000) begin
            errors++; $display("FAIL bounce_mode got mode=%0d run=%b led=%b exp 1/0/0000", MODE, RUNNING, LED);
        end
        tick(1, 0, 0, 0, 0);
        checks++;
        if (LED !== 4'b0001) begin errors++; $display("FAIL bounce_seed got %b exp 0001", LED); end
        for (int k = 0; k < 7; k++) begin
            repeat (16) tick(0, 0, 0, 0, 0);
            checks++;
            if (LED !== 4'(exp_seq[k])) begin
                errors++; $display("FAIL bounce_step%0d got %b exp %b", k + 1, LED, 4'(exp_seq[k]));
            end
        end
    endtask

    task automatic test_count();
        tick(0, 1, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        checks++;
        if (MODE !== 2'd2 || LED !== 4'b0000 || RUNNING !== 1'b1) begin
            errors++; $display("FAIL count_start got mode=%0d led=%b run=%b exp 2/0000/1", MODE, LED, RUNNING);
        end
        for (int k = 1; k <= 17; k++) begin
            repeat (16) tick(0, 0, 0, 0, 0);
            checks++;
            if (LED !== 4'(k % 16)) begin errors++; $display("FAIL count_step%0d got %b exp %b", k, LED, 4'(k % 16)); end
        end
        tick(0, 1, 0, 0, 0);
        checks++;
        if (MODE !== 2'd0 || RUNNING !== 1'b0 || LED !== 4'b0000) begin
            errors++; $display("FAIL count_exit got mode=%0d run=%b led=%b exp 0/0/0000", MODE, RUNNING, LED);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        repeat (10) tick(0, 0, 0, 0, 0);
        checks++;
        if (RUNNING !== 1'b1 || SPEED !== 3'd2) begin
            errors++; $display("FAIL mid_pre got run=%b spd=%0d exp 1/2", RUNNING, SPEED);
        end
        tick(1, 1, 1, 0, 1);
        checks++;
        if (LED !== 4'b0000 || RUNNING !== 1'b0 || SPEED !== 3'd0 || MODE !== 2'd0) begin
            errors++; $display("FAIL mid_reset got led=%b run=%b spd=%0d mode=%0d exp 0000/0/0/0", LED, RUNNING, SPEED, MODE);
        end
    endtask

    task automatic test_random();
        bit s, m, u, d, r;
        for (int c = 0; c < 4000; c++) begin
            s = ($urandom_range(23) == 0);
            m = ($urandom_range(59) == 0);
            u = ($urandom_range(19) == 0);
            d = ($urandom_range(19) == 0);
            r = ($urandom_range(699) == 0);
            tick(s, m, u, d, r);
            checks++;
            if (LED !== 4'(exp_led())) begin
                errors++; $display("FAIL rand_led cyc=%0d got %b exp %b", c, LED, 4'(exp_led()));
            end
            checks++;
            if (RUNNING !== (m_state == 1)) begin
                errors++; $display("FAIL rand_run cyc=%0d got %b exp %b", c, RUNNING, (m_state == 1));
            end
            checks++;
            if (SPEED !== 3'(m_speed)) begin
                errors++; $display("FAIL rand_speed cyc=%0d got %0d exp %0d", c, SPEED, m_speed);
            end
            checks++;
            if (MODE !== 2'(m_mode)) begin
                errors++; $display("FAIL rand_mode cyc=%0d got %0d exp %0d", c, MODE, m_mode);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotate();
        test_speed();
        test_priority();
        test_bounce();
        test_count();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
